// File: rtl/stack_controller_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : stack_controller_pkg
//  Description : Shared encodings for the stack calculator storage path:
//                memory modes, memory address width, stack op codes, the
//                stack controller state encodings and an op decode helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package stack_controller_pkg;

    // Memory interface
    localparam int         MEMORY_ADDR_BITS  = 3;
    localparam logic [1:0] MEMORY_MODE_NONE  = 2'b00;
    localparam logic [1:0] MEMORY_MODE_READ  = 2'b01;
    localparam logic [1:0] MEMORY_MODE_WRITE = 2'b10;
    localparam logic [1:0] MEMORY_MODE_CLEAR = 2'b11;

    // Stack command op codes
    localparam logic [1:0] STACK_OP_CLEAR = 2'b00;
    localparam logic [1:0] STACK_OP_PUSH  = 2'b01;
    localparam logic [1:0] STACK_OP_POP   = 2'b10;
    localparam logic [1:0] STACK_OP_PEEK  = 2'b11;

    // Stack controller state encodings
    localparam logic [2:0] STACK_STATE_IDLE     = 3'd0;
    localparam logic [2:0] STACK_STATE_WRITE    = 3'd1;
    localparam logic [2:0] STACK_STATE_READ     = 3'd2;
    localparam logic [2:0] STACK_STATE_CAPTURE  = 3'd3;
    localparam logic [2:0] STACK_STATE_CLEARING = 3'd4;

    // One-hot view of a command op code
    typedef struct packed {
        logic clear;
        logic push;
        logic pop;
        logic peek;
    } stack_op_dec_t;

    function automatic stack_op_dec_t decode_op(input logic [1:0] op_code);
        stack_op_dec_t d;
        d.clear = (op_code == STACK_OP_CLEAR);
        d.push  = (op_code == STACK_OP_PUSH);
        d.pop   = (op_code == STACK_OP_POP);
        d.peek  = (op_code == STACK_OP_PEEK);
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stack_controller.sv
`default_nettype none
// ============================================================================
//  Module      : stack_controller
//  Description : Stack front-end for the storage memory. Converts PUSH, POP,
//                PEEK and CLEAR commands into registered memory mode/address/
//                data cycles, owns the stack pointer and full/empty status,
//                flags overflow/underflow and returns read nibbles with a
//                one-cycle valid pulse.
//                Optional macro STACKCTL_ERR_STICKY_EN: when defined, error
//                is latched until CLEAR or rst; otherwise it is a one-cycle
//                pulse after the offending command.
//  Revision    : 1.0 - initial release
// ============================================================================
module stack_controller
    import stack_controller_pkg::*;
#(
    parameter int ADDR_BITS = MEMORY_ADDR_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 op_valid,
    input  logic [1:0]           op,
    output logic                 op_ready,
    input  logic [3:0]           push_data,
    output logic [3:0]           result,
    output logic                 result_valid,
    output logic                 full,
    output logic                 empty,
    output logic [ADDR_BITS:0]   depth,
    output logic                 error,
    output logic [1:0]           mem_mode,
    output logic [ADDR_BITS-1:0] mem_address,
    output logic [3:0]           mem_data_in,
    input  logic [3:0]           mem_data_out
);

    localparam logic [ADDR_BITS:0] c_full_depth = {1'b1, {ADDR_BITS{1'b0}}};
    localparam logic [ADDR_BITS:0] c_one        = {{ADDR_BITS{1'b0}}, 1'b1};

    logic [2:0]           r_state;
    logic [ADDR_BITS:0]   r_sp;
    logic [1:0]           r_mem_mode;
    logic [ADDR_BITS-1:0] r_mem_address;
    logic [3:0]           r_mem_data_in;
    logic [3:0]           r_result;
    logic                 r_result_valid;
    logic                 r_error;

    logic                 w_accept;
    stack_op_dec_t        w_dec;
    logic                 w_full;
    logic                 w_empty;
    logic [ADDR_BITS:0]   w_sp_inc;
    logic [ADDR_BITS:0]   w_sp_dec;
    logic                 w_err_event;

    assign op_ready     = (r_state == STACK_STATE_IDLE) && !rst;
    assign w_accept     = op_valid && op_ready;
    assign w_dec        = decode_op(op);
    assign w_full       = (r_sp == c_full_depth);
    assign w_empty      = (r_sp == '0);
    assign w_sp_inc     = r_sp + c_one;
    assign w_sp_dec     = r_sp - c_one;
    // Overflow (PUSH while full) or underflow (POP/PEEK while empty)
    assign w_err_event  = w_accept &&
                          ((w_dec.push && w_full) ||
                           ((w_dec.pop || w_dec.peek) && w_empty));

    assign full         = w_full;
    assign empty        = w_empty;
    assign depth        = r_sp;
    assign result       = r_result;
    assign result_valid = r_result_valid;
    assign error        = r_error;
    assign mem_mode     = r_mem_mode;
    assign mem_address  = r_mem_address;
    assign mem_data_in  = r_mem_data_in;

    // Command FSM: pointer update, registered memory cycle and result capture
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= STACK_STATE_IDLE;
            r_sp           <= '0;
            r_mem_mode     <= MEMORY_MODE_NONE;
            r_mem_address  <= '0;
            r_mem_data_in  <= '0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
        end else begin
            r_result_valid <= 1'b0;
            case (r_state)
                STACK_STATE_IDLE: begin
                    // Error cases are consumed here without any memory cycle
                    if (w_accept) begin
                        if (w_dec.push && !w_full) begin
                            r_mem_address <= r_sp[ADDR_BITS-1:0];
                            r_mem_data_in <= push_data;
                            r_sp          <= w_sp_inc;
                            r_mem_mode    <= MEMORY_MODE_WRITE;
                            r_state       <= STACK_STATE_WRITE;
                        end else if ((w_dec.pop || w_dec.peek) && !w_empty) begin
                            r_mem_address <= w_sp_dec[ADDR_BITS-1:0];
                            if (w_dec.pop) begin
                                r_sp <= w_sp_dec;
                            end
                            r_mem_mode    <= MEMORY_MODE_READ;
                            r_state       <= STACK_STATE_READ;
                        end else if (w_dec.clear) begin
                            r_sp          <= '0;
                            r_mem_mode    <= MEMORY_MODE_CLEAR;
                            r_state       <= STACK_STATE_CLEARING;
                        end
                    end
                end
                STACK_STATE_WRITE: begin
                    r_mem_mode <= MEMORY_MODE_NONE;
                    r_state    <= STACK_STATE_IDLE;
                end
                STACK_STATE_READ: begin
                    // Memory latches the cell on this edge; data is seen in CAPTURE
                    r_mem_mode <= MEMORY_MODE_NONE;
                    r_state    <= STACK_STATE_CAPTURE;
                end
                STACK_STATE_CAPTURE: begin
                    r_result       <= mem_data_out;
                    r_result_valid <= 1'b1;
                    r_state        <= STACK_STATE_IDLE;
                end
                STACK_STATE_CLEARING: begin
                    r_mem_mode <= MEMORY_MODE_NONE;
                    r_state    <= STACK_STATE_IDLE;
                end
                default: begin
                    r_mem_mode <= MEMORY_MODE_NONE;
                    r_state    <= STACK_STATE_IDLE;
                end
            endcase
        end
    end

`ifdef STACKCTL_ERR_STICKY_EN
    // Error latches on overflow/underflow and holds until CLEAR or reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_error <= 1'b0;
        end else if (w_err_event) begin
            r_error <= 1'b1;
        end else if (w_accept && w_dec.clear) begin
            r_error <= 1'b0;
        end
    end
`else
    // Error pulses for one cycle after the offending command is accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            r_error <= 1'b0;
        end else begin
            r_error <= w_err_event;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_stack_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stack_controller
//  Description : Self-checking bench for stack_controller driving a
//                behavioural nibble memory. Directed command table, reset
//                corner case and randomized commands against a queue model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stack_controller;
    import stack_controller_pkg::*;

    localparam int AB  = 3;
    localparam int CAP = 1 << AB;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          op_valid = 1'b0;
    logic [1:0]    op = 2'b00;
    logic          op_ready;
    logic [3:0]    push_data = 4'h0;
    logic [3:0]    result;
    logic          result_valid;
    logic          full;
    logic          empty;
    logic [AB:0]   depth;
    logic          error;
    logic [1:0]    mem_mode;
    logic [AB-1:0] mem_address;
    logic [3:0]    mem_data_in;
    logic [3:0]    mem_data_out;

    always #5 clk = ~clk;

    stack_controller #(.ADDR_BITS(AB)) dut (
        .clk          (clk),
        .rst          (rst),
        .op_valid     (op_valid),
        .op           (op),
        .op_ready     (op_ready),
        .push_data    (push_data),
        .result       (result),
        .result_valid (result_valid),
        .full         (full),
        .empty        (empty),
        .depth        (depth),
        .error        (error),
        .mem_mode     (mem_mode),
        .mem_address  (mem_address),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out)
    );

    // Behavioural memory: write/read on the clock edge, CLEAR zeroes data_out
    logic [3:0] cells [CAP];
    logic [3:0] r_dout;
    initial begin
        for (int i = 0; i < CAP; i++) cells[i] = 4'h0;
        r_dout = 4'h0;
    end
    always @(posedge clk) begin
        case (mem_mode)
            MEMORY_MODE_WRITE: cells[mem_address] <= mem_data_in;
            MEMORY_MODE_READ:  r_dout <= cells[mem_address];
            MEMORY_MODE_CLEAR: r_dout <= 4'h0;
            default: ;
        endcase
    end
    assign mem_data_out = r_dout;

    int n_checks = 0;
    int n_fail   = 0;
    logic sticky_err = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one command and check the following three cycles
    task automatic run_and_check(input logic [1:0] c_op, input logic [3:0] c_data,
                                 input logic exp_err, input logic exp_rv,
                                 input logic [3:0] exp_res, input int exp_depth,
                                 input int exp_addr);
        logic [1:0] exp_mode;
        logic       exp_e1;
        logic       exp_e2;
        int         guard;
        if (exp_err)                  exp_mode = MEMORY_MODE_NONE;
        else if (c_op == STACK_OP_PUSH)  exp_mode = MEMORY_MODE_WRITE;
        else if (c_op == STACK_OP_CLEAR) exp_mode = MEMORY_MODE_CLEAR;
        else                          exp_mode = MEMORY_MODE_READ;
        if (exp_err) sticky_err = 1'b1;
        else if (c_op == STACK_OP_CLEAR) sticky_err = 1'b0;
`ifdef STACKCTL_ERR_STICKY_EN
        exp_e1 = sticky_err;
        exp_e2 = sticky_err;
`else
        exp_e1 = exp_err;
        exp_e2 = 1'b0;
`endif
        @(negedge clk);
        guard = 0;
        while (!op_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!op_ready) begin
            chk("op_ready_timeout", 0, 1);
            return;
        end
        op_valid  = 1'b1;
        op        = c_op;
        push_data = c_data;
        @(posedge clk);
        #1 op_valid = 1'b0;
        @(negedge clk);
        chk("mode_c1", mem_mode, exp_mode);
        chk("error_c1", error, exp_e1);
        chk("rv_c1", result_valid, 0);
        if (!exp_err && c_op != STACK_OP_CLEAR) chk("addr_c1", mem_address, exp_addr);
        if (!exp_err && c_op == STACK_OP_PUSH)  chk("din_c1", mem_data_in, c_data);
        @(negedge clk);
        chk("mode_c2", mem_mode, MEMORY_MODE_NONE);
        chk("error_c2", error, exp_e2);
        chk("rv_c2", result_valid, 0);
        @(negedge clk);
        chk("rv_c3", result_valid, exp_rv);
        chk("result_c3", result, exp_res);
        chk("depth_c3", depth, exp_depth);
        chk("full_c3", full, exp_depth == CAP);
        chk("empty_c3", empty, exp_depth == 0);
    endtask

    typedef struct {
        logic [1:0] op;
        logic [3:0] data;
        logic       err;
        logic       rv;
        logic [3:0] res;
        int         depth;
    } vec_t;

    function automatic vec_t mk(input logic [1:0] o, input logic [3:0] d, input logic e,
                                input logic v, input logic [3:0] r, input int dp);
        vec_t t;
        t.op = o; t.data = d; t.err = e; t.rv = v; t.res = r; t.depth = dp;
        return t;
    endfunction

    vec_t tbl [25];

    initial begin
        int prev_depth;
        int addr;
        logic [3:0] m_res;
        logic [3:0] q [$];

        // Directed table
        tbl[0]  = mk(STACK_OP_POP,   4'h0, 1, 0, 4'h0, 0);
        tbl[1]  = mk(STACK_OP_PUSH,  4'h3, 0, 0, 4'h0, 1);
        tbl[2]  = mk(STACK_OP_PUSH,  4'h7, 0, 0, 4'h0, 2);
        tbl[3]  = mk(STACK_OP_PUSH,  4'hA, 0, 0, 4'h0, 3);
        tbl[4]  = mk(STACK_OP_POP,   4'h0, 0, 1, 4'hA, 2);
        tbl[5]  = mk(STACK_OP_POP,   4'h0, 0, 1, 4'h7, 1);
        tbl[6]  = mk(STACK_OP_POP,   4'h0, 0, 1, 4'h3, 0);
        tbl[7]  = mk(STACK_OP_PUSH,  4'h5, 0, 0, 4'h3, 1);
        tbl[8]  = mk(STACK_OP_PEEK,  4'h0, 0, 1, 4'h5, 1);
        tbl[9]  = mk(STACK_OP_PEEK,  4'h0, 0, 1, 4'h5, 1);
        tbl[10] = mk(STACK_OP_POP,   4'h0, 0, 1, 4'h5, 0);
        tbl[11] = mk(STACK_OP_PUSH,  4'h2, 0, 0, 4'h5, 1);
        tbl[12] = mk(STACK_OP_CLEAR, 4'h0, 0, 0, 4'h5, 0);
        tbl[13] = mk(STACK_OP_POP,   4'h0, 1, 0, 4'h5, 0);
        for (int i = 0; i < 8; i++)
            tbl[14+i] = mk(STACK_OP_PUSH, 4'(i + 1), 0, 0, 4'h5, i + 1);
        tbl[22] = mk(STACK_OP_PUSH,  4'hF, 1, 0, 4'h5, 8);
        tbl[23] = mk(STACK_OP_POP,   4'h0, 0, 1, 4'h8, 7);
        tbl[24] = mk(STACK_OP_CLEAR, 4'h0, 0, 0, 4'h8, 0);

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_op_ready", op_ready, 0);
        chk("rst_depth", depth, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_error", error, 0);
        chk("rst_result", result, 0);
        chk("rst_rv", result_valid, 0);
        chk("rst_mode", mem_mode, MEMORY_MODE_NONE);
        chk("rst_addr", mem_address, 0);
        chk("rst_din", mem_data_in, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("op_ready_after_rst", op_ready, 1);

        prev_depth = 0;
        for (int i = 0; i < 25; i++) begin
            addr = (tbl[i].op == STACK_OP_PUSH) ? prev_depth : prev_depth - 1;
            run_and_check(tbl[i].op, tbl[i].data, tbl[i].err, tbl[i].rv,
                          tbl[i].res, tbl[i].depth, addr);
            prev_depth = tbl[i].depth;
        end

        // Reset while a POP is in the READ state
        run_and_check(STACK_OP_PUSH, 4'h9, 0, 0, 4'h8, 1, 0);
        @(negedge clk);
        op_valid = 1'b1;
        op       = STACK_OP_POP;
        @(posedge clk);
        #1 op_valid = 1'b0;
        @(negedge clk);
        chk("rst_mid_mode_read", mem_mode, MEMORY_MODE_READ);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_op_ready", op_ready, 0);
        chk("rst_mid_depth", depth, 0);
        chk("rst_mid_mode", mem_mode, MEMORY_MODE_NONE);
        chk("rst_mid_rv", result_valid, 0);
        chk("rst_mid_result", result, 0);
        rst = 1'b0;
        sticky_err = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst_mid_rv_after", result_valid, 0);
            chk("rst_mid_ready_after", op_ready, 1);
        end

        // Randomized commands against a queue model
        m_res = 4'h0;
        q.delete();
        for (int n = 0; n < 150; n++) begin
            int         r;
            logic [1:0] c_op;
            logic [3:0] c_d;
            logic       e;
            logic       v;
            r   = $urandom_range(0, 9);
            c_d = 4'($urandom_range(0, 15));
            if (r == 0)      c_op = STACK_OP_CLEAR;
            else if (r <= 4) c_op = STACK_OP_PUSH;
            else if (r <= 7) c_op = STACK_OP_POP;
            else             c_op = STACK_OP_PEEK;
            e = 1'b0;
            v = 1'b0;
            addr = 0;
            case (c_op)
                STACK_OP_PUSH: begin
                    if (q.size() == CAP) e = 1'b1;
                    else begin addr = q.size(); q.push_back(c_d); end
                end
                STACK_OP_POP: begin
                    if (q.size() == 0) e = 1'b1;
                    else begin addr = q.size() - 1; m_res = q.pop_back(); v = 1'b1; end
                end
                STACK_OP_PEEK: begin
                    if (q.size() == 0) e = 1'b1;
                    else begin addr = q.size() - 1; m_res = q[$]; v = 1'b1; end
                end
                default: q.delete();
            endcase
            run_and_check(c_op, c_d, e, v, m_res, q.size(), addr);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
